// File: rtl/lsu_pkg.sv
// Shared op codes, FSM state encoding and default widths for the load/store unit.
package lsu_pkg;

  localparam int unsigned LSU_AW     = 8;
  localparam int unsigned LSU_DW     = 32;
  localparam int unsigned LSU_MEM_AW = 4;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_STORE  = 2'b01,
    OP_AMOADD = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB,
    ST_RESP
  } state_e;

endpackage

// File: rtl/load_store_unit.sv
// Single-outstanding LOAD/STORE/AMOADD initiator for a single-port data memory.
// Optional LSU_BOUNDS_CHECK_EN: out-of-range word addresses fault instead of wrapping.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned AW     = LSU_AW,
  parameter int unsigned DW     = LSU_DW,
  parameter int unsigned MEM_AW = LSU_MEM_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [AW-1:0]     req_addr,
  input  logic [DW-1:0]     req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              mem_st,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW-1:0]       old_q, old_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                fault_q, fault_d;
  logic                oob;

`ifdef LSU_BOUNDS_CHECK_EN
  assign oob = (req_addr >> MEM_AW) != '0;
`else
  logic addr_hi_unused;
  assign addr_hi_unused = ^req_addr[AW-1:MEM_AW];
  assign oob = 1'b0;
`endif

  assign mem_addr  = addr_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    old_d     = old_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    fault_d   = fault_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_st    = 1'b0;
    mem_wdata = '0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = op_e'(req_op);
          addr_d  = req_addr[MEM_AW-1:0];
          wdata_d = req_wdata;
          fault_d = (op_e'(req_op) == OP_RSVD) || oob;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
        // A faulting request never touches memory, whatever its op code.
        if (fault_q) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          unique case (op_q)
            OP_LOAD: rdata_d = mem_rdata;
            OP_STORE: begin
              mem_st    = 1'b1;
              mem_wdata = wdata_q;
              rdata_d   = '0;
            end
            OP_AMOADD: begin
              old_d   = mem_rdata;
              state_d = ST_WB;
            end
            default: begin
              err_d   = 1'b1;
              rdata_d = '0;
            end
          endcase
        end
      end
      ST_WB: begin
        mem_st    = 1'b1;
        mem_wdata = old_q + wdata_q;
        rdata_d   = old_q;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: bench-side memory, word-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_st;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.AW(8), .DW(32), .MEM_AW(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_st(mem_st), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory seen by the DUT.
  logic [31:0] env_mem [16];
  logic        fill = 1'b1;
  int          st_count = 0;
  assign mem_rdata = env_mem[mem_addr];
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= 32'hA5A5_0000 + i;
    end else if (mem_st) begin
      env_mem[mem_addr] <= mem_wdata;
    end
    if (reset_n && mem_st) st_count++;
  end

  // Reference model state.
  logic [31:0] ref_mem [16];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model's expected response.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rsp_valid) begin
        chk("rsp_expected", {31'b0, exp_valid}, 32'd1);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
      end
      chk("mem_st_ctx", {31'b0, mem_st & (rsp_valid | req_ready)}, 32'd0);
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] wd,
                       input int hold, output logic [31:0] got, output logic got_err);
    logic [3:0]  ea;
    logic        err;
    logic [31:0] erd;
    int          est, elat, edges, st_base;
    ea   = addr[3:0];
    err  = (op == 2'b11);
`ifdef LSU_BOUNDS_CHECK_EN
    if (addr >= 8'd16) err = 1'b1;
`endif
    erd  = '0;
    est  = 0;
    elat = 2;
    if (!err) begin
      case (op)
        2'b00: erd = ref_mem[ea];
        2'b01: begin ref_mem[ea] = wd; est = 1; end
        2'b10: begin erd = ref_mem[ea]; ref_mem[ea] = ref_mem[ea] + wd; est = 1; elat = 3; end
        default: ;
      endcase
    end

    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    st_base   = st_count;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = $urandom;
    exp_rdata = erd;
    exp_err   = err;
    exp_valid = 1'b1;

    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!rsp_valid && edges < 10);
    chk("latency", 32'(edges + 1), 32'(elat));
    got     = rsp_rdata;
    got_err = rsp_err;

    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_clr", {31'b0, rsp_valid}, 32'd0);
    chk("rsp_err_clr", {31'b0, rsp_err}, 32'd0);
    chk("req_ready_back", {31'b0, req_ready}, 32'd1);
    chk("st_pulses", 32'(st_count - st_base), 32'(est));
    if (!err) chk("mem_addr_hold", {28'b0, mem_addr}, {28'b0, ea});
  endtask

  logic [31:0] got;
  logic        gerr;
  int          st_base;

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA5A5_0000 + i;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_mem_st", {31'b0, mem_st}, 32'd0);
    chk("rst_mem_addr", {28'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    fill    = 1'b0;
    reset_n = 1'b1;

    // STORE then LOAD same word.
    do_op(2'b01, 8'd5, 32'h1234_5678, 0, got, gerr);
    do_op(2'b00, 8'd5, 32'h0, 0, got, gerr);
    chk("lit_load5", got, 32'h1234_5678);
    chk("lit_load5_err", {31'b0, gerr}, 32'd0);

    // AMOADD carry wrap.
    do_op(2'b01, 8'd3, 32'hFFFF_FFFF, 0, got, gerr);
    do_op(2'b10, 8'd3, 32'd2, 0, got, gerr);
    chk("lit_amo_old", got, 32'hFFFF_FFFF);
    do_op(2'b00, 8'd3, 32'h0, 0, got, gerr);
    chk("lit_amo_new", got, 32'h1);

    // Response backpressure.
    do_op(2'b00, 8'd5, 32'h0, 5, got, gerr);
    chk("lit_hold_load", got, 32'h1234_5678);

    // Reserved op.
    do_op(2'b11, 8'd6, 32'hDEAD_BEEF, 0, got, gerr);
    chk("lit_rsvd_rdata", got, 32'h0);
    chk("lit_rsvd_err", {31'b0, gerr}, 32'd1);

    // Out-of-range address.
    do_op(2'b01, 8'h15, 32'hCAFE_F00D, 0, got, gerr);
    do_op(2'b00, 8'd5, 32'h0, 0, got, gerr);
`ifdef LSU_BOUNDS_CHECK_EN
    chk("lit_oob_nowrite", got, 32'h1234_5678);
`else
    chk("lit_oob_wrap", got, 32'hCAFE_F00D);
`endif

    // Reset asserted while AMOADD is in its write-back cycle.
    @(negedge clk);
    st_base   = st_count;
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_addr  = 8'd7;
    req_wdata = 32'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("wb_mem_st", {31'b0, mem_st}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_wb_mem_st", {31'b0, mem_st}, 32'd0);
    chk("rst_wb_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_wb_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_wb_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_wb_mem_addr", {28'b0, mem_addr}, 32'd0);
    chk("rst_wb_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_wb_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_wb_no_write", 32'(st_count - st_base), 32'd0);
    do_op(2'b00, 8'd7, 32'h0, 0, got, gerr);
    chk("lit_rst_word7", got, 32'hA5A5_0007);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_op(op, 8'($urandom), $urandom, int'($urandom_range(0, 3)), got, gerr);
    end

    for (int i = 0; i < 16; i++) chk("final_mem", env_mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
